// File: rtl/mrd_sideband_align.sv
// mrd_sideband_align
// -----------------------------------------------------------------------------
// Carries the per-lane write-back sideband (bank index, bank address, radix
// factor, valid) of the mixed-radix DFT stage through a fixed shift chain so
// that it arrives at memory in the same cycle as the butterfly/twiddle data.
// Two output taps are available: a long one for the twiddled path and a short
// one for the bypass path. Switching between them drains the chain first
// (in_ready is dropped) so items never overlap, duplicate or reorder.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   flush             synchronous clear of every in-flight item
//   in_valid/ready    input handshake; accept = in_valid && in_ready
//   in_short          item uses the short (bypass) latency
//   in_factor         radix factor travelling with the item
//   in_bank_index     LANES x wIDX packed bank indices, lane 0 in LSBs
//   in_bank_addr      LANES x wADDR packed bank addresses, lane 0 in LSBs
//   out_valid         aligned item present this cycle
//   out_factor/out_bank_index/out_bank_addr
//                     aligned sideband, held at the last value when idle
//   busy              items in flight, or draining for a latency change
// -----------------------------------------------------------------------------
module mrd_sideband_align #(
   parameter int LANES     = 5,
   parameter int wIDX      = 3,
   parameter int wADDR     = 8,
   parameter int LAT_LONG  = 24,
   parameter int LAT_SHORT = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_short,
   input  logic [2:0]             in_factor,
   input  logic [LANES*wIDX-1:0]  in_bank_index,
   input  logic [LANES*wADDR-1:0] in_bank_addr,
   output logic                   out_valid,
   output logic [2:0]             out_factor,
   output logic [LANES*wIDX-1:0]  out_bank_index,
   output logic [LANES*wADDR-1:0] out_bank_addr,
   output logic                   busy
);

   localparam int IW = LANES * wIDX;
   localparam int AW = LANES * wADDR;
   localparam int CW = $clog2(LAT_LONG + 1);
   localparam int TW = $clog2(LAT_LONG);
   localparam logic [TW-1:0] TAP_LONG  = TW'(LAT_LONG - 1);
   localparam logic [TW-1:0] TAP_SHORT = TW'(LAT_SHORT - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t          state;
   logic            active_short;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic [TW-1:0]   tap;
   logic            accept;
   logic            retire;

   logic [LAT_LONG-1:0] v;
   logic [2:0]          fac_q  [LAT_LONG];
   logic [IW-1:0]       idx_q  [LAT_LONG];
   logic [AW-1:0]       addr_q [LAT_LONG];

   logic [2:0]          hold_fac;
   logic [IW-1:0]       hold_idx;
   logic [AW-1:0]       hold_addr;

   // A new item may enter whenever the chain is empty or it uses the same
   // latency as the items already in flight; a mismatching item waits.
   assign tap      = active_short ? TAP_SHORT : TAP_LONG;
   assign in_ready = !flush && ((cnt == '0) || (in_short == active_short));
   assign accept   = in_valid && in_ready;
   assign retire   = v[tap];
   assign busy     = (cnt != '0) || (state == DRAIN);

   // In-flight count: accept and retire in the same cycle cancel out.
   always_comb begin
      cnt_next = cnt;
      if (accept && !retire) begin
         cnt_next = cnt + CW'(1);
      end else if (!accept && retire) begin
         cnt_next = cnt - CW'(1);
      end
   end

   // Valid chain. Stages past the active tap never carry a valid bit, so an
   // item is presented exactly once and a leftover short item can never
   // resurface at the long tap after the mode changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else if (flush) begin
         v <= '0;
      end else begin
         v[0] <= accept;
         for (int k = 1; k < LAT_LONG; k++) begin
            v[k] <= (TW'(k) <= tap) ? v[k-1] : 1'b0;
         end
      end
   end

   // Data chain shifts unconditionally; contents of invalid stages are unused,
   // so no reset is needed here.
   always_ff @(posedge clk) begin
      fac_q[0]  <= in_factor;
      idx_q[0]  <= in_bank_index;
      addr_q[0] <= in_bank_addr;
      for (int k = 1; k < LAT_LONG; k++) begin
         fac_q[k]  <= fac_q[k-1];
         idx_q[k]  <= idx_q[k-1];
         addr_q[k] <= addr_q[k-1];
      end
   end

   // Remember the last retired sideband so the outputs stay stable between
   // items and read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_fac  <= '0;
         hold_idx  <= '0;
         hold_addr <= '0;
      end else if (retire) begin
         hold_fac  <= fac_q[tap];
         hold_idx  <= idx_q[tap];
         hold_addr <= addr_q[tap];
      end
   end

   assign out_valid      = retire;
   assign out_factor     = retire ? fac_q[tap]  : hold_fac;
   assign out_bank_index = retire ? idx_q[tap]  : hold_idx;
   assign out_bank_addr  = retire ? addr_q[tap] : hold_addr;

   // Control FSM together with the counter and latency mode. The mode only
   // changes on an accept, and an accept with a different mode is only
   // possible once the chain is empty, so the tap never moves under an item.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         active_short <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         cnt <= cnt_next;
         if (accept) begin
            active_short <= in_short;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!accept && (cnt_next == '0)) begin
                  state <= IDLE;
               end else if (in_valid && (in_short != active_short) && (cnt != '0)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_next == '0) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mrd_sideband_align.sv
// tb_mrd_sideband_align
// -----------------------------------------------------------------------------
// Directed bench for mrd_sideband_align. A queue-based model tracks every
// accepted item together with the clock edge after which it must be visible,
// and a negedge process compares the DUT against it every cycle. Hand-derived
// edge distances pin the model for each scenario.
// -----------------------------------------------------------------------------
module tb_mrd_sideband_align;

   localparam int LANES     = 5;
   localparam int wIDX      = 3;
   localparam int wADDR     = 8;
   localparam int LAT_LONG  = 24;
   localparam int LAT_SHORT = 3;
   localparam int IW        = LANES * wIDX;
   localparam int AW        = LANES * wADDR;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_short;
   logic [2:0]    in_factor;
   logic [IW-1:0] in_bank_index;
   logic [AW-1:0] in_bank_addr;
   logic          out_valid;
   logic [2:0]    out_factor;
   logic [IW-1:0] out_bank_index;
   logic [AW-1:0] out_bank_addr;
   logic          busy;

   mrd_sideband_align #(
      .LANES(LANES), .wIDX(wIDX), .wADDR(wADDR),
      .LAT_LONG(LAT_LONG), .LAT_SHORT(LAT_SHORT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_short(in_short),
      .in_factor(in_factor), .in_bank_index(in_bank_index),
      .in_bank_addr(in_bank_addr), .out_valid(out_valid),
      .out_factor(out_factor), .out_bank_index(out_bank_index),
      .out_bank_addr(out_bank_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            exit_at;
      logic [2:0]    f;
      logic [IW-1:0] idx;
      logic [AW-1:0] addr;
   } item_t;

   item_t mq[$];
   int    acc_edges[$];
   int    out_edges[$];
   int    edge_cnt = 0;
   int    checks   = 0;
   int    passes   = 0;
   int    max_cnt  = 0;
   bit    model_short = 1'b0;
   bit    acc_flag    = 1'b0;

   always @(posedge clk) edge_cnt++;

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Per-cycle comparison and model update. Items are visible during the
   // cycle following edge (accept_edge + latency - 1); the in-flight count is
   // simply the number of queued items.
   always @(negedge clk) begin
      item_t it;
      bit    exp_valid;
      bit    exp_ready;
      bit    acc;
      if (!rst_n) begin
         mq.delete();
         model_short = 1'b0;
         acc_flag    = 1'b0;
      end else begin
         exp_valid = (mq.size() > 0) && (mq[0].exit_at == edge_cnt);
         checkOutput("out_valid", out_valid, exp_valid);
         if (exp_valid && out_valid) begin
            checkOutput("out_factor", out_factor, mq[0].f);
            checkOutput("out_bank_index", out_bank_index, mq[0].idx);
            checkOutput("out_bank_addr", out_bank_addr, mq[0].addr);
         end
         exp_ready = !flush && ((mq.size() == 0) || (in_short == model_short));
         checkOutput("in_ready", in_ready, exp_ready);
         checkOutput("busy", busy, mq.size() != 0);
         checkOutput("cnt_bound", dut.cnt <= LAT_LONG, 1);
         if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
         if (out_valid) out_edges.push_back(edge_cnt);
         acc = in_valid && exp_ready;
         if (flush) begin
            mq.delete();
         end else begin
            if (exp_valid) void'(mq.pop_front());
            if (acc) begin
               it.exit_at = edge_cnt + (in_short ? LAT_SHORT : LAT_LONG);
               it.f       = in_factor;
               it.idx     = in_bank_index;
               it.addr    = in_bank_addr;
               mq.push_back(it);
               model_short = in_short;
               acc_edges.push_back(edge_cnt + 1);
            end
         end
         acc_flag = acc;
      end
   end

   // Present one item and hold it until the model says it was accepted.
   task automatic applyStimulus(input bit s, input logic [2:0] f, input int a);
      bit            done;
      logic [IW-1:0] ix;
      logic [AW-1:0] ad;
      done = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         ix[l*wIDX +: wIDX]   = 3'((a + l) % 8);
         ad[l*wADDR +: wADDR] = 8'((a + 37 * l) % 256);
      end
      for (int n = 0; n < 100 && !done; n++) begin
         @(posedge clk);
         #1;
         in_valid      = 1'b1;
         in_short      = s;
         in_factor     = f;
         in_bank_index = ix;
         in_bank_addr  = ad;
         @(negedge clk);
         #1;
         done = acc_flag;
      end
      if (!done) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic idleCycles(input int n);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic clearMarks();
      acc_edges.delete();
      out_edges.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_short = 1'b0;
      in_factor = '0; in_bank_index = '0; in_bank_addr = '0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_out_factor", out_factor, 0);
      checkOutput("reset_out_addr", out_bank_addr, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Long stream: 30 back-to-back items
      clearMarks();
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 3'd1, i);
      idleCycles(30);
      checkOutput("long_count", out_edges.size(), 30);
      checkOutput("long_latency", out_edges[0] - acc_edges[0], 23);
      checkOutput("long_contig_out", out_edges[29] - out_edges[0], 29);
      checkOutput("long_contig_in", acc_edges[29] - acc_edges[0], 29);

      // Short stream: 10 items
      clearMarks();
      max_cnt = 0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd2, 100 + i);
      idleCycles(10);
      checkOutput("short_count", out_edges.size(), 10);
      checkOutput("short_latency", out_edges[0] - acc_edges[0], 2);
      checkOutput("short_max_cnt", max_cnt, 3);

      // Long-to-short switch with the short items held at the input
      clearMarks();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'd3, 200 + i);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd4, 50 + i);
      idleCycles(30);
      checkOutput("l2s_count", out_edges.size(), 8);
      checkOutput("l2s_last_long_out", out_edges[4] - acc_edges[0], 27);
      checkOutput("l2s_first_short_acc", acc_edges[5] - acc_edges[0], 29);
      checkOutput("l2s_first_short_out", out_edges[5] - acc_edges[0], 31);

      // Short-to-long switch
      clearMarks();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd5, 70 + i);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd6, 90 + i);
      idleCycles(30);
      checkOutput("s2l_out_count", out_edges.size(), 8);
      checkOutput("s2l_acc_count", acc_edges.size(), 8);
      checkOutput("s2l_first_long_acc", acc_edges[4] - acc_edges[0], 7);
      checkOutput("s2l_first_long_out", out_edges[4] - acc_edges[0], 30);

      // Flush with 12 items in flight
      clearMarks();
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 3'd7, 3 * i);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_busy_next", busy, 0);
      clearMarks();
      idleCycles(24);
      checkOutput("flush_no_output", out_edges.size(), 0);
      clearMarks();
      applyStimulus(1'b0, 3'd1, 5);
      idleCycles(30);
      checkOutput("post_flush_count", out_edges.size(), 1);
      checkOutput("post_flush_latency", out_edges[0] - acc_edges[0], 23);

      // Asynchronous reset mid-stream, between clock edges
      clearMarks();
      for (int i = 0; i < 26; i++) applyStimulus(1'b0, 3'd1, i);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("pre_reset_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_addr", out_bank_addr, 0);
      checkOutput("rst_out_factor", out_factor, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_busy", busy, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      clearMarks();
      idleCycles(30);
      checkOutput("rst_no_residual", out_edges.size(), 0);
      clearMarks();
      applyStimulus(1'b0, 3'd2, 9);
      idleCycles(30);
      checkOutput("post_rst_count", out_edges.size(), 1);
      checkOutput("post_rst_latency", out_edges[0] - acc_edges[0], 23);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mrd_sideband_align.md
# mrd_sideband_align

Parametrised sideband alignment pipeline for the mixed-radix DFT stage. It carries per-lane bank index/address, factor and valid alongside the variable-latency radix-2/3/4/5 + twiddle datapath, so the write-back sideband reaches memory in the same cycle as its data. It has two selectable latencies: long for the twiddled path, short for the bypass path. It supports lane count, widths and latencies as parameters. On a latency-mode change it drains safely with back-pressure, so sideband items never collide or reorder.

## Interface
Parameters:
- LANES, 5, number of parallel butterfly lanes
- wIDX, 3, bank index width per lane
- wADDR, 8, bank address width per lane
- LAT_LONG, 24, latency in cycles for the twiddled path (LAT_SHORT < LAT_LONG ≤ 64)
- LAT_SHORT, 3, latency in cycles for the bypass path (≥ 1)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of all in-flight items
- in_valid  in  1  input item present
- in_ready  out  1  block accepts the item this cycle
- in_short  in  1  item uses LAT_SHORT; asserted by upstream when twdl_demontr==3
- in_factor  in  3  radix factor carried with the item
- in_bank_index  in  LANES*wIDX  packed per-lane bank index, lane 0 in LSBs
- in_bank_addr  in  LANES*wADDR  packed per-lane bank address, lane 0 in LSBs
- out_valid  out  1  aligned item present
- out_factor  out  3  factor of the emerging item
- out_bank_index  out  LANES*wIDX  aligned bank index
- out_bank_addr  out  LANES*wADDR  aligned bank address
- busy  out  1  at least one item in flight, or state is DRAIN

## Operation
- Acceptance: an item is accepted when in_valid && in_ready is sampled at a clock edge.
- Storage: a shift chain of LAT_LONG stages, each holding {v, factor, index, addr}.
  - Stage 0 loads the input each edge, with v = accept.
  - Each stage k+1 loads from stage k every edge. There is no stall inside the chain.
- Active mode: register active_short (reset 0) selects the tap.
  - Tap is LAT_SHORT-1 when active_short = 1, otherwise LAT_LONG-1.
  - Outputs are driven from the tap stage.
  - v of every stage beyond the tap is forced to 0, so an item retires exactly once.
- In-flight counter: width clog2(LAT_LONG+1).
  - Increments on accept and decrements on retire (tap v = 1).
  - Accept and retire in the same cycle leave it unchanged.
- in_ready (combinational) = !flush && (cnt == 0 || in_short == active_short).
- active_short loads in_short on every accept.
- State machine:
  - IDLE (cnt == 0): goes to RUN on accept.
  - RUN: goes to DRAIN when in_valid && in_short != active_short && cnt != 0. Goes to IDLE when cnt reaches 0 with no accept.
  - DRAIN: in_ready is low for the mismatching item. Goes to IDLE when cnt reaches 0. The held item is accepted in that IDLE cycle and the state goes to RUN.
- flush: all stage v bits and cnt are cleared at the next edge, and state goes to IDLE. No accept happens in a flush cycle. active_short is kept.
- Data fields of stages with v = 0 are don't-care. Output data holds its last value while out_valid = 0; the bench checks data only when out_valid = 1.

## Timing
- Reset: every output is 0 except in_ready, which is 1. All v bits are 0, cnt = 0, state is IDLE, active_short = 0.
- Latency: an item accepted at edge t is presented with out_valid = 1 in the cycle after edge t+LAT-1, where LAT is the active latency.
- Throughput: one item per cycle while the mode is unchanged; there are no bubbles.
- Mode-switch penalty: in_ready stays low until the last old-mode item retires. The first new-mode item is accepted in the cycle cnt becomes 0, which is at most LAT_LONG cycles after the stall began.
- Ordering: items exit strictly in acceptance order. No two items exit in the same cycle.
- Reset mid-operation: all in-flight items are discarded immediately, with no output pulse.
- Counter overflow is impossible, because cnt ≤ LAT_LONG by construction. Verification asserts this.

## Test plan
- Long stream: 30 back-to-back items with in_short = 0 and addr = 0..29 → out_valid begins 24 cycles after the first accept; addr 0..29 appear in order, contiguous, with in_ready always 1.
- Short stream: 10 items with in_short = 1 → each appears 3 cycles after its accept, and cnt never exceeds 3.
- Long-to-short switch: 5 long items, then short items held at in_valid → in_ready stays low until the 5th long item retires. The first short item is accepted that cycle and exits 3 cycles later, with no overlap and no duplicate.
- Short-to-long switch: 4 short items, then long items → no stale short item re-emerges at tap 23, and the total out_valid count equals the total accept count.
- Flush with 12 items in flight → no out_valid on the following 24 cycles, busy = 0 next cycle, and a new item after the flush exits with normal latency.
- Async reset asserted mid-stream, between clock edges → outputs go to 0 immediately, in_ready = 1, and there is no residual output after release.
